// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous reset, clear (bubble) beats enable.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clr,
    input  logic   en,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection, imem addressing and IF/ID capture.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_f,
    input  logic               stall_d,
    input  logic               flush_d,
    input  logic               pc_src_d,
    input  logic [31:0]        pc_branch_d,
    input  logic               jump_d,
    input  logic [31:0]        pc_jump_d,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rd,
    output logic [31:0]        pc_f,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_plus4_d,
    output logic               valid_d,
    output logic [31:0]        fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic [31:0] w_pc_plus4_f;
    logic [31:0] w_pc_next;
    logic        w_load_d;
    if_id_t      w_if_id_d;
    if_id_t      w_if_id_q;

    assign w_pc_plus4_f = r_pc + 32'd4;

    // Jump outranks branch; redirect targets are forced word-aligned.
    always_comb begin
        w_pc_next = w_pc_plus4_f;
        if (jump_d) begin
            w_pc_next = {pc_jump_d[31:2], 2'b00};
        end else if (pc_src_d) begin
            w_pc_next = {pc_branch_d[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (!stall_f) begin
            r_pc <= w_pc_next;
        end
    end

    assign w_load_d  = !flush_d && !stall_d;
    assign w_if_id_d = '{instr: imem_rd, pc_plus4: w_pc_plus4_f, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_d),
        .en    (!stall_d),
        .d     (w_if_id_d),
        .q     (w_if_id_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'h0;
        end else if (w_load_d) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr   = r_pc[IMEM_AW+1:2];
    assign pc_f        = r_pc;
    assign instr_d     = w_if_id_q.instr;
    assign pc_plus4_d  = w_if_id_q.pc_plus4;
    assign valid_d     = w_if_id_q.valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory word k = 32'h2000_0000 + k.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f, stall_d, flush_d;
    logic        pc_src_d, jump_d;
    logic [31:0] pc_branch_d, pc_jump_d;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] pc_f, instr_d, pc_plus4_d, fetch_count;
    logic        valid_d;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_rd = 32'h2000_0000 + {26'd0, imem_addr};

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_d    (pc_src_d),
        .pc_branch_d (pc_branch_d),
        .jump_d      (jump_d),
        .pc_jump_d   (pc_jump_d),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .fetch_count (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_p4, input logic e_valid, input logic [31:0] e_cnt);
        chk({tag, ".pc_f"},        pc_f,                 e_pc);
        chk({tag, ".instr_d"},     instr_d,              e_instr);
        chk({tag, ".pc_plus4_d"},  pc_plus4_d,           e_p4);
        chk({tag, ".valid_d"},     {31'd0, valid_d},     {31'd0, e_valid});
        chk({tag, ".fetch_count"}, fetch_count,          e_cnt);
        $display("step %-12s pc_f=%h instr_d=%h pc_plus4_d=%h valid_d=%b fetch_count=%0d",
                 tag, pc_f, instr_d, pc_plus4_d, valid_d, fetch_count);
    endtask

    task automatic idle();
        stall_f = 0; stall_d = 0; flush_d = 0;
        pc_src_d = 0; jump_d = 0; pc_branch_d = 0; pc_jump_d = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        step();
        step();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("reset.imem_addr", {26'd0, imem_addr}, 32'h0);

        // Free run
        reset = 0;
        step();
        chk_all("run1", 32'h4, 32'h2000_0000, 32'h4, 1'b1, 32'd1);
        step();
        chk_all("run2", 32'h8, 32'h2000_0001, 32'h8, 1'b1, 32'd2);

        // Branch to 0x20 with flush at PC 0x8
        pc_src_d = 1; pc_branch_d = 32'h20; flush_d = 1;
        step();
        idle();
        chk_all("br_bubble", 32'h20, 32'h0, 32'h0, 1'b0, 32'd2);
        step();
        chk_all("br_target", 32'h24, 32'h2000_0008, 32'h24, 1'b1, 32'd3);

        // Jump beats branch; unaligned jump target 0x43 loads 0x40
        jump_d = 1; pc_jump_d = 32'h43; pc_src_d = 1; pc_branch_d = 32'h20; flush_d = 1;
        step();
        idle();
        chk_all("jmp_bubble", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3);
        step();
        chk_all("jmp_target", 32'h44, 32'h2000_0010, 32'h44, 1'b1, 32'd4);

        // Get to PC 0xC with word 2 in IF/ID
        jump_d = 1; pc_jump_d = 32'h8; flush_d = 1;
        step();
        idle();
        step();
        chk_all("pre_stall", 32'hC, 32'h2000_0002, 32'hC, 1'b1, 32'd5);

        // Full freeze for three cycles
        stall_f = 1; stall_d = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("stall%0d", i), 32'hC, 32'h2000_0002, 32'hC, 1'b1, 32'd5);
            chk("stall.imem_addr", {26'd0, imem_addr}, 32'h3);
        end
        idle();
        step();
        chk_all("resume", 32'h10, 32'h2000_0003, 32'h10, 1'b1, 32'd6);

        // Flush beats stall_d
        stall_f = 1; stall_d = 1; flush_d = 1;
        step();
        idle();
        chk_all("flush_stall", 32'h10, 32'h0, 32'h0, 1'b0, 32'd6);
        step();
        chk_all("after_fl", 32'h14, 32'h2000_0004, 32'h14, 1'b1, 32'd7);

        // PC 0xFC -> 0x100 aliases to word 0
        jump_d = 1; pc_jump_d = 32'hFC; flush_d = 1;
        step();
        idle();
        chk("pc_fc.imem_addr", {26'd0, imem_addr}, 32'h3F);
        step();
        chk_all("pc_100", 32'h100, 32'h2000_003F, 32'h100, 1'b1, 32'd8);
        chk("pc_100.imem_addr", {26'd0, imem_addr}, 32'h0);
        step();
        chk_all("pc_104", 32'h104, 32'h2000_0000, 32'h104, 1'b1, 32'd9);

        // Jump to 0xFFFF_FFFC then wrap to 0
        jump_d = 1; pc_jump_d = 32'hFFFF_FFFC;
        step();
        idle();
        chk_all("pc_top", 32'hFFFF_FFFC, 32'h2000_0001, 32'h108, 1'b1, 32'd10);
        step();
        chk_all("pc_wrap", 32'h0, 32'h2000_003F, 32'h0, 1'b1, 32'd11);

        // Reset mid-stall with redirect and flush also asserted
        stall_f = 1; stall_d = 1; pc_src_d = 1; pc_branch_d = 32'h80; flush_d = 1;
        reset = 1;
        step();
        chk_all("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        chk_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        reset = 0;
        idle();
        step();
        chk_all("post_rst", 32'h4, 32'h2000_0000, 32'h4, 1'b1, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
